// File: rtl/instruction_memory_loadable_pkg.sv
// Shared MIPS fetch-side definitions: memory state encoding, default fill word, fault record.
package instruction_memory_loadable_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } imem_state_e;

    localparam logic [1:0]  ST_CLEAR = 2'(CLEAR);
    localparam logic [1:0]  ST_LOAD  = 2'(LOAD);
    localparam logic [1:0]  ST_RUN   = 2'(RUN);

    localparam logic [31:0] DEFAULT_NOP_WORD = 32'h0000_0000;

    typedef struct packed {
        logic misaligned;
        logic range;
    } fetch_fault_t;

    function automatic logic is_misaligned(input logic [1:0] lsb);
        return |lsb;
    endfunction

endpackage

// File: rtl/instruction_memory_loadable_if.sv
// Load stream and fetch port of the loadable instruction memory.
// master = program loader / fetch stage, slave = the memory block.
interface instruction_memory_loadable_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 64
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                  reload;
    logic                  load_valid;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  load_last;
    logic                  load_ready;
    logic                  fetch_en;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] instruction;
    logic                  instr_valid;
    logic                  fault_misaligned;
    logic                  fault_range;
    logic                  running;
    logic [CW-1:0]         load_count;
    logic                  load_full;

    modport master (
        output reload, load_valid, load_data, load_last, fetch_en, address,
        input  load_ready, instruction, instr_valid, fault_misaligned, fault_range,
               running, load_count, load_full
    );

    modport slave (
        input  reload, load_valid, load_data, load_last, fetch_en, address,
        output load_ready, instruction, instr_valid, fault_misaligned, fault_range,
               running, load_count, load_full
    );

endinterface

// File: rtl/instruction_memory_loadable_imem_array.sv
// Single-port synchronous RAM; one shared address, write has priority over read.
// Read data appears one cycle after re and holds while re is low.
module imem_array #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 64
) (
    input  logic                         clock,
    input  logic                         we,
    input  logic [$clog2(DEPTH)-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0]        wdata,
    input  logic                         re,
    input  logic [$clog2(DEPTH)-1:0]     raddr,
    output logic [DATA_WIDTH-1:0]        rdata
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [AW-1:0]         w_addr;

    // writes only happen in CLEAR/LOAD and reads only in RUN, so we selects the port owner
    assign w_addr = we ? waddr : raddr;

    always_ff @(posedge clock) begin
        if (we) begin
            r_mem[w_addr] <= wdata;
        end else if (re) begin
            r_rdata <= r_mem[w_addr];
        end
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/instruction_memory_loadable.sv
// Loadable instruction memory: clears to NOP, accepts a program stream, then serves PC fetches.
// Fetch latency 1 cycle, one fetch per cycle; load_ready is high throughout LOAD only.
module instruction_memory_loadable
    import instruction_memory_loadable_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH      = 64,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD   = DATA_WIDTH'(DEFAULT_NOP_WORD)
) (
    input  logic                          clock,
    input  logic                          reset,
    instruction_memory_loadable_if.slave  bus
);
    localparam int                    IW       = $clog2(DEPTH);
    localparam int                    CW       = IW + 1;
    localparam logic [IW-1:0]         PTR_LAST = IW'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_W  = ADDR_WIDTH'(DEPTH);

    logic [1:0]            r_state;
    logic [IW-1:0]         r_ptr;
    logic [CW-1:0]         r_load_count;
    logic                  r_load_full;
    logic                  r_sel_ram;
    logic [DATA_WIDTH-1:0] r_instr_hold;
    logic                  r_instr_valid;
    fetch_fault_t          r_fault;

    logic                  w_load_ready;
    logic                  w_accept;
    logic                  w_fetch_act;
    logic                  w_fetch_ok;
    logic [ADDR_WIDTH-1:0] w_word;
    logic [IW-1:0]         w_fetch_idx;
    fetch_fault_t          w_fault;
    logic                  w_we;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_rdata;

    assign w_load_ready       = (r_state == ST_LOAD);
    assign w_accept           = w_load_ready && bus.load_valid;
    assign w_fetch_act        = (r_state == ST_RUN) && bus.fetch_en;
    assign w_word             = bus.address >> 2;
    assign w_fetch_idx        = bus.address[2 +: IW];
    assign w_fault.misaligned = is_misaligned(bus.address[1:0]);
    assign w_fault.range      = (w_word >= DEPTH_W);
    assign w_fetch_ok         = w_fetch_act && !w_fault.misaligned && !w_fault.range;
    assign w_we               = (r_state == ST_CLEAR) || w_accept;
    assign w_wdata            = (r_state == ST_CLEAR) ? NOP_WORD : bus.load_data;

    imem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_array (
        .clock (clock),
        .we    (w_we),
        .waddr (r_ptr),
        .wdata (w_wdata),
        .re    (w_fetch_ok),
        .raddr (w_fetch_idx),
        .rdata (w_rdata)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_CLEAR;
            r_ptr        <= '0;
            r_load_count <= '0;
            r_load_full  <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_ptr <= r_ptr + IW'(1);
                    if (r_ptr == PTR_LAST) begin
                        r_state <= ST_LOAD;
                        r_ptr   <= '0;
                    end
                end
                ST_LOAD: begin
                    if (w_accept) begin
                        r_ptr        <= r_ptr + IW'(1);
                        r_load_count <= r_load_count + CW'(1);
                        // load_last wins over the depth limit, so a full-length program is not flagged
                        if (bus.load_last) begin
                            r_state <= ST_RUN;
                        end else if (r_ptr == PTR_LAST) begin
                            r_state     <= ST_RUN;
                            r_load_full <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.reload) begin
                        r_state      <= ST_CLEAR;
                        r_ptr        <= '0;
                        r_load_count <= '0;
                        r_load_full  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_CLEAR;
                    r_ptr   <= '0;
                end
            endcase
        end
    end

    // r_instr_hold keeps the last visible word so idle cycles present a stable instruction
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sel_ram     <= 1'b0;
            r_instr_hold  <= NOP_WORD;
            r_instr_valid <= 1'b0;
            r_fault       <= '0;
        end else begin
            r_sel_ram          <= w_fetch_ok;
            r_instr_valid      <= w_fetch_ok;
            r_fault.misaligned <= w_fetch_act && w_fault.misaligned;
            r_fault.range      <= w_fetch_act && w_fault.range;
            if (w_fetch_act && !w_fetch_ok) begin
                r_instr_hold <= NOP_WORD;
            end else if (r_sel_ram) begin
                r_instr_hold <= w_rdata;
            end
        end
    end

    assign bus.load_ready       = w_load_ready;
    assign bus.running          = (r_state == ST_RUN);
    assign bus.load_count       = r_load_count;
    assign bus.load_full        = r_load_full;
    assign bus.instruction      = r_sel_ram ? w_rdata : r_instr_hold;
    assign bus.instr_valid      = r_instr_valid;
    assign bus.fault_misaligned = r_fault.misaligned;
    assign bus.fault_range      = r_fault.range;

endmodule

// File: tb/tb_instruction_memory_loadable.sv
// Bench for the loadable instruction memory with DEPTH=8, NOP_WORD=0.
module tb_instruction_memory_loadable;

    logic clock = 1'b0;
    logic reset = 1'b1;

    instruction_memory_loadable_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(8)) bus ();

    instruction_memory_loadable #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .DEPTH      (8),
        .NOP_WORD   (32'h0000_0000)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int vecs = 0;
    int errs = 0;

    logic [31:0] m_mem [8];
    logic [31:0] m_instr;
    bit          m_run;
    logic [31:0] e_instr;
    logic        e_vld, e_mis, e_rng;
    logic [31:0] prog [8];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 8; i++) m_mem[i] = 32'h0;
    endtask

    // Drive one fetch cycle and predict the outcome from the memory model.
    task automatic fetch_step(input bit en, input logic [31:0] a);
        bus.fetch_en = en;
        bus.address  = a;
        if (en && m_run) begin
            e_mis = (a % 4) != 0;
            e_rng = (a / 4) >= 8;
            if (e_mis || e_rng) begin
                e_instr = 32'h0;
                e_vld   = 1'b0;
            end else begin
                e_instr = m_mem[a / 4];
                e_vld   = 1'b1;
            end
        end else begin
            e_instr = m_instr;
            e_vld   = 1'b0;
            e_mis   = 1'b0;
            e_rng   = 1'b0;
        end
        tick();
        m_instr      = e_instr;
        bus.fetch_en = 1'b0;
    endtask

    task automatic wait_ready(input int limit);
        int n = 0;
        while (!bus.load_ready && n < limit) begin
            tick();
            n++;
        end
        vecs++;
        if (bus.load_ready !== 1'b1) begin
            errs++;
            $display("FAIL wait_load_ready: load_ready=%b after %0d cycles, required 1", bus.load_ready, n);
        end
    endtask

    task automatic load_prog(input int n, input bit use_last);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                bus.load_valid = 1'b0;
                tick();
            end
            bus.load_valid = 1'b1;
            bus.load_data  = prog[i];
            bus.load_last  = use_last && (i == n - 1);
            tick();
            m_mem[i] = prog[i];
        end
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        m_run = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        vecs++;
        if ({bus.instruction, bus.instr_valid, bus.fault_misaligned, bus.fault_range, bus.load_ready,
             bus.running, bus.load_count, bus.load_full} !== {32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0}) begin
            errs++;
            $display("FAIL reset_values: instr=%h vld=%b mis=%b rng=%b rdy=%b run=%b cnt=%0d full=%b, required all zero",
                     bus.instruction, bus.instr_valid, bus.fault_misaligned, bus.fault_range, bus.load_ready,
                     bus.running, bus.load_count, bus.load_full);
        end
        reset   = 1'b0;
        m_instr = 32'h0;
        m_run   = 1'b0;
        clear_model();
        vecs++;
        if (bus.load_ready !== 1'b0) begin
            errs++;
            $display("FAIL clear_ready_c0: load_ready=%b, required 0", bus.load_ready);
        end
        for (int k = 1; k <= 8; k++) begin
            fetch_step(1'b1, 32'h0);
            vecs++;
            if (bus.load_ready !== (k == 8)) begin
                errs++;
                $display("FAIL clear_ready_c%0d: load_ready=%b, required %b", k, bus.load_ready, (k == 8));
            end
            vecs++;
            if ({bus.instr_valid, bus.fault_misaligned, bus.fault_range} !== 3'b000) begin
                errs++;
                $display("FAIL fetch_before_run: vld/mis/rng=%b%b%b, required 000",
                         bus.instr_valid, bus.fault_misaligned, bus.fault_range);
            end
        end
    endtask

    task automatic test_normal_load();
        logic [31:0] addrs [4];
        prog[0] = 32'h0880_0000;
        prog[1] = 32'h2001_0005;
        prog[2] = 32'h0000_0000;
        load_prog(3, 1'b1);
        vecs++;
        if ({bus.running, bus.load_count, bus.load_full, bus.load_ready} !== {1'b1, 4'd3, 1'b0, 1'b0}) begin
            errs++;
            $display("FAIL normal_load_status: run=%b cnt=%0d full=%b rdy=%b, required 1 3 0 0",
                     bus.running, bus.load_count, bus.load_full, bus.load_ready);
        end
        addrs = '{32'h4, 32'h10, 32'h0, 32'h8};
        for (int i = 0; i < 4; i++) begin
            fetch_step(1'b1, addrs[i]);
            vecs++;
            if ({bus.instruction, bus.instr_valid, bus.fault_misaligned, bus.fault_range} !== {e_instr, e_vld, e_mis, e_rng}) begin
                errs++;
                $display("FAIL normal_fetch_%h: got %h v%b m%b r%b, required %h v%b m%b r%b", addrs[i],
                         bus.instruction, bus.instr_valid, bus.fault_misaligned, bus.fault_range, e_instr, e_vld, e_mis, e_rng);
            end
        end
    endtask

    task automatic test_faults();
        logic [31:0] a;
        logic [31:0] fixed [5];
        fixed = '{32'h6, 32'h20, 32'h22, 32'h4, 32'h1C};
        for (int i = 0; i < 17; i++) begin
            if (i < 5)                         a = fixed[i];
            else if ($urandom_range(0, 1) == 0) a = $urandom;
            else                               a = $urandom_range(0, 63);
            fetch_step(i != 16, a);
            vecs++;
            if ({bus.instruction, bus.instr_valid, bus.fault_misaligned, bus.fault_range} !== {e_instr, e_vld, e_mis, e_rng}) begin
                errs++;
                $display("FAIL fault_fetch_%h: got %h v%b m%b r%b, required %h v%b m%b r%b", a,
                         bus.instruction, bus.instr_valid, bus.fault_misaligned, bus.fault_range, e_instr, e_vld, e_mis, e_rng);
            end
        end
    endtask

    task automatic test_back_to_back(input int cycles);
        logic [31:0] a;
        bit          en;
        for (int i = 0; i < cycles; i++) begin
            en = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 4) == 0) a = $urandom_range(0, 47);
            else                           a = 32'($urandom_range(0, 9)) * 4;
            fetch_step(en, a);
            vecs++;
            if ({bus.instruction, bus.instr_valid, bus.fault_misaligned, bus.fault_range} !== {e_instr, e_vld, e_mis, e_rng}) begin
                errs++;
                $display("FAIL b2b_fetch_%h_en%b: got %h v%b m%b r%b, required %h v%b m%b r%b", a, en,
                         bus.instruction, bus.instr_valid, bus.fault_misaligned, bus.fault_range, e_instr, e_vld, e_mis, e_rng);
            end
        end
    endtask

    task automatic test_reload();
        bus.reload = 1'b1;
        fetch_step(1'b1, 32'h0);
        bus.reload = 1'b1;
        m_run = 1'b0;
        clear_model();
        vecs++;
        if ({bus.instruction, bus.instr_valid} !== {e_instr, e_vld}) begin
            errs++;
            $display("FAIL reload_fetch: got %h v%b, required %h v%b", bus.instruction, bus.instr_valid, e_instr, e_vld);
        end
        vecs++;
        if ({bus.running, bus.load_count, bus.load_full} !== {1'b0, 4'd0, 1'b0}) begin
            errs++;
            $display("FAIL reload_status: run=%b cnt=%0d full=%b, required 0 0 0", bus.running, bus.load_count, bus.load_full);
        end
        // reload held high through CLEAR must not restart the clear sequence
        for (int k = 1; k <= 8; k++) begin
            tick();
            vecs++;
            if (bus.load_ready !== (k == 8)) begin
                errs++;
                $display("FAIL reload_ready_c%0d: load_ready=%b, required %b", k, bus.load_ready, (k == 8));
            end
        end
        bus.reload = 1'b0;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 8; i++) prog[i] = 32'(i + 1);
        load_prog(8, 1'b0);
        vecs++;
        if ({bus.running, bus.load_count, bus.load_full, bus.load_ready} !== {1'b1, 4'd8, 1'b1, 1'b0}) begin
            errs++;
            $display("FAIL overflow_status: run=%b cnt=%0d full=%b rdy=%b, required 1 8 1 0",
                     bus.running, bus.load_count, bus.load_full, bus.load_ready);
        end
        bus.load_valid = 1'b1;
        bus.load_data  = 32'h0000_0099;
        bus.load_last  = 1'b1;
        tick();
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        vecs++;
        if ({bus.running, bus.load_count, bus.load_full} !== {1'b1, 4'd8, 1'b1}) begin
            errs++;
            $display("FAIL overflow_ninth: run=%b cnt=%0d full=%b, required 1 8 1", bus.running, bus.load_count, bus.load_full);
        end
        fetch_step(1'b1, 32'h1C);
        vecs++;
        if ({bus.instruction, bus.instr_valid} !== {e_instr, e_vld}) begin
            errs++;
            $display("FAIL overflow_fetch_1c: got %h v%b, required %h v%b", bus.instruction, bus.instr_valid, e_instr, e_vld);
        end
        fetch_step(1'b1, 32'h0);
        vecs++;
        if ({bus.instruction, bus.instr_valid} !== {e_instr, e_vld}) begin
            errs++;
            $display("FAIL overflow_fetch_0: got %h v%b, required %h v%b", bus.instruction, bus.instr_valid, e_instr, e_vld);
        end
    endtask

    task automatic test_reset_midload();
        bus.reload = 1'b1;
        tick();
        bus.reload = 1'b0;
        m_run = 1'b0;
        wait_ready(20);
        bus.load_valid = 1'b1;
        bus.load_data  = 32'hDEAD_0001;
        tick();
        bus.load_data  = 32'hDEAD_0002;
        tick();
        bus.load_valid = 1'b0;
        reset = 1'b1;
        tick();
        vecs++;
        if ({bus.instruction, bus.instr_valid, bus.fault_misaligned, bus.fault_range, bus.load_ready,
             bus.running, bus.load_count, bus.load_full} !== {32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0}) begin
            errs++;
            $display("FAIL midload_reset_values: instr=%h vld=%b mis=%b rng=%b rdy=%b run=%b cnt=%0d full=%b, required all zero",
                     bus.instruction, bus.instr_valid, bus.fault_misaligned, bus.fault_range, bus.load_ready,
                     bus.running, bus.load_count, bus.load_full);
        end
        tick();
        reset   = 1'b0;
        m_instr = 32'h0;
        clear_model();
        wait_ready(20);
        prog[0] = $urandom;
        load_prog(1, 1'b1);
        vecs++;
        if ({bus.running, bus.load_count} !== {1'b1, 4'd1}) begin
            errs++;
            $display("FAIL midload_reload_status: run=%b cnt=%0d, required 1 1", bus.running, bus.load_count);
        end
        fetch_step(1'b1, 32'h4);
        vecs++;
        if ({bus.instruction, bus.instr_valid} !== {e_instr, e_vld}) begin
            errs++;
            $display("FAIL midload_old_gone: got %h v%b, required %h v%b", bus.instruction, bus.instr_valid, e_instr, e_vld);
        end
        fetch_step(1'b1, 32'h0);
        vecs++;
        if ({bus.instruction, bus.instr_valid} !== {e_instr, e_vld}) begin
            errs++;
            $display("FAIL midload_word0: got %h v%b, required %h v%b", bus.instruction, bus.instr_valid, e_instr, e_vld);
        end
    endtask

    task automatic test_random_program();
        int n;
        bus.reload = 1'b1;
        tick();
        bus.reload = 1'b0;
        m_run = 1'b0;
        clear_model();
        wait_ready(20);
        n = $urandom_range(1, 8);
        for (int i = 0; i < 8; i++) prog[i] = $urandom;
        load_prog(n, 1'b1);
        vecs++;
        if ({bus.running, bus.load_count, bus.load_full} !== {1'b1, 4'(n), 1'b0}) begin
            errs++;
            $display("FAIL random_prog_status: run=%b cnt=%0d full=%b, required 1 %0d 0",
                     bus.running, bus.load_count, bus.load_full, n);
        end
        test_back_to_back(30);
    endtask

    initial begin
        bus.reload     = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = 32'h0;
        bus.load_last  = 1'b0;
        bus.fetch_en   = 1'b0;
        bus.address    = 32'h0;
        m_instr        = 32'h0;
        m_run          = 1'b0;
        clear_model();

        test_reset();
        test_normal_load();
        test_faults();
        test_back_to_back(60);
        test_reload();
        test_overflow();
        test_reset_midload();
        for (int r = 0; r < 3; r++) test_random_program();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

endmodule
